pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Second-generation decode controller for the 5-stage MIPS pipeline.
- Decodes OpCode/Funct in ID and registers the control bundle into the ID/EX stage, with bubble insertion on stall and on flush.
- Adds a parametrised multi-cycle MULT/DIV sequencer that stalls HI/LO dependants and flags illegal opcodes.

Parameters:
MULT_CYCLES, 4, cycles a mult/multu occupies the MD unit (>=1)
DIV_CYCLES, 32, cycles a div/divu occupies the MD unit (>=1)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
OpCode  in  6  instr[31:26]
Funct  in  6  instr[5:0]
stall_in  in  1  external stall (load-use hazard unit)
flush_in  in  1  squash ID (taken branch/jump)
id_PCSrc  out  2  comb: 01 j/jal, 10 jr/jalr, 00 otherwise
id_IsJump  out  1  comb: j, jal, jr, jalr
stall_out  out  1  comb: freeze PC and IF/ID
ex_valid  out  1  ID/EX holds a real instruction
ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrcA, ex_ALUSrcB, ex_ExtOp, ex_LuiOp  out  1 each  registered controls
ex_RegDst  out  2  00 rt, 01 rd, 10 $ra
ex_MemToReg  out  2  00 ALU, 01 mem, 10 PC+4, 11 HI/LO
ex_HiLoSel  out  1  0 LO, 1 HI (mfhi)
ex_ALUOp  out  4  [2:0] 000 add, 001 or, 010 R-type, 011 xor, 100 and, 101 slt; [3] = OpCode[0]
ex_BranchOp  out  3  001 beq, 010 bne, 011 blez, 100 bgtz, 101 REGIMM, 000 none
ex_illegal  out  1  unsupported opcode/funct
md_start  out  1  comb pulse: launch MD op this cycle
md_op  out  2  comb: 00 mult, 01 multu, 10 div, 11 divu (valid with md_start)
md_busy  out  1  registered: MD sequencer in BUSY
md_done  out  1  registered one-cycle pulse: result in HI/LO

Behaviour:
- Reset (reset=0, async): all ex_* outputs = 0, md_busy = 0, md_done = 0, state IDLE, counter = 0.
- Decode (comb, gated by id_valid):
  - RegWrite is 0 for sw, j, REGIMM, beq–bgtz, jr, mult/multu/div/divu; 1 for all other legal instructions.
  - RegDst: 10 for jal/jalr, 01 for other R-type, 00 otherwise.
  - MemRead only for lw (0x23); MemWrite only for sw (0x2b).
  - MemToReg: 01 lw; 10 jal/jalr; 11 mfhi (0x10) / mflo (0x12); 00 otherwise.
  - ALUSrcA = 1 for sll/srl/sra; ALUSrcB = 1 for any non-R-type.
  - ExtOp = 0 for R-type, andi, ori, xori; 1 otherwise. LuiOp only for 0x0f.
- Legal set: R-type funct {00,02,03,04,06,07,08,09,10,12,18,19,1a,1b,20–27,2a,2b}; opcodes {01–0f, 23, 2b}. Anything else sets ex_illegal=1 and forces RegWrite/MemWrite/MemRead/BranchOp/PCSrc to 0.
- Stall: md_dep = id_valid & (is_md | mfhi | mflo). stall_out = stall_in | (md_dep & md_busy).
- ID/EX register, priority reset > flush_in > stall_out > load:
  - flush_in or stall_out → bubble (ex_valid=0, all controls 0).
  - Otherwise capture decode with ex_valid = id_valid.
- Latency: ID to ex_* is 1 cycle.
- MD FSM, IDLE → BUSY:
  - md_start = id_valid & is_md & ~flush_in & ~stall_out. Only possible in IDLE, because is_md while BUSY stalls.
  - On start, counter = MULT_CYCLES-1 (mult/multu) or DIV_CYCLES-1 (div/divu).
  - BUSY: decrement each cycle. When counter==0, next edge goes to IDLE with md_done=1 for exactly one cycle.
  - Total BUSY duration = N cycles.
- Boundary cases:
  - In the md_done cycle md_busy is already 0, so a waiting mfhi proceeds then.
  - flush_in while BUSY does not cancel the in-flight MD op.
  - flush_in and stall_in together → bubble, no md_start.
  - stall_in asserted during the start cycle suppresses md_start; it retries once stall_in drops.
  - Async reset mid-BUSY returns to IDLE with no md_done.

Test Plan:
- Reset: hold reset=0 with addi (OpCode=08) in ID → all ex_*=0, md_busy=0; release → next edge ex_RegWrite=1, ex_ALUSrcB=1, ex_ExtOp=1, ex_ALUOp=0000.
- Decode sweep: lw → MemRead=1, MemToReg=01; jal → id_PCSrc=01, RegDst=10, MemToReg=10; jr (Funct=08) → PCSrc=10, RegWrite=0; ori → ALUOp=1001, ExtOp=0; OpCode=3f → ex_illegal=1, RegWrite=0.
- mult then mflo (MULT_CYCLES=4): md_start/md_op=00 at t0; md_busy high t1–t4; mflo in ID stalls while md_busy; md_done at t5 and mflo captured at t5 with MemToReg=11, HiLoSel=0.
- Back-to-back div/divu (DIV_CYCLES=32): second div stalls 32 cycles, md_start fires the cycle md_done=1 with md_op=11.
- Flush/stall priority: flush_in=1 + stall_in=1 with div in ID → ex_valid=0, md_start=0; stall_in alone with sw → bubble, ex_MemWrite=0.
- Reset at BUSY counter=10 → md_busy=0 immediately, no md_done pulse, next mult restarts the full MULT_CYCLES count.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// ============================================================================
// Module      : pipe_ctrl_unit_if
// Description : ID-stage decode inputs and ID/EX control bundle of the
//               pipeline decode controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_unit_if;
    // ID-stage inputs
    logic       id_valid;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       stall_in;
    logic       flush_in;

    // ID-stage combinational outputs
    logic [1:0] id_PCSrc;
    logic       id_IsJump;
    logic       stall_out;

    // ID/EX registered control bundle
    logic       ex_valid;
    logic       ex_RegWrite;
    logic       ex_MemRead;
    logic       ex_MemWrite;
    logic       ex_ALUSrcA;
    logic       ex_ALUSrcB;
    logic       ex_ExtOp;
    logic       ex_LuiOp;
    logic [1:0] ex_RegDst;
    logic [1:0] ex_MemToReg;
    logic       ex_HiLoSel;
    logic [3:0] ex_ALUOp;
    logic [2:0] ex_BranchOp;
    logic       ex_illegal;

    // MULT/DIV sequencer
    logic       md_start;
    logic [1:0] md_op;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_valid, OpCode, Funct, stall_in, flush_in,
        input  id_PCSrc, id_IsJump, stall_out,
        input  ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrcA,
               ex_ALUSrcB, ex_ExtOp, ex_LuiOp, ex_RegDst, ex_MemToReg,
               ex_HiLoSel, ex_ALUOp, ex_BranchOp, ex_illegal,
        input  md_start, md_op, md_busy, md_done
    );

    modport slave (
        input  id_valid, OpCode, Funct, stall_in, flush_in,
        output id_PCSrc, id_IsJump, stall_out,
        output ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrcA,
               ex_ALUSrcB, ex_ExtOp, ex_LuiOp, ex_RegDst, ex_MemToReg,
               ex_HiLoSel, ex_ALUOp, ex_BranchOp, ex_illegal,
        output md_start, md_op, md_busy, md_done
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : MIPS ID-stage decoder with ID/EX control register, bubble
//               insertion and a multi-cycle MULT/DIV sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_unit_if.slave bus
);

    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_REGIMM = 6'h01;
    localparam logic [5:0] c_OP_J      = 6'h02;
    localparam logic [5:0] c_OP_JAL    = 6'h03;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_BNE    = 6'h05;
    localparam logic [5:0] c_OP_BLEZ   = 6'h06;
    localparam logic [5:0] c_OP_BGTZ   = 6'h07;
    localparam logic [5:0] c_OP_SLTI   = 6'h0a;
    localparam logic [5:0] c_OP_SLTIU  = 6'h0b;
    localparam logic [5:0] c_OP_ANDI   = 6'h0c;
    localparam logic [5:0] c_OP_ORI    = 6'h0d;
    localparam logic [5:0] c_OP_XORI   = 6'h0e;
    localparam logic [5:0] c_OP_LUI    = 6'h0f;
    localparam logic [5:0] c_OP_LW     = 6'h23;
    localparam logic [5:0] c_OP_SW     = 6'h2b;

    localparam logic [5:0] c_FN_SLL    = 6'h00;
    localparam logic [5:0] c_FN_SRL    = 6'h02;
    localparam logic [5:0] c_FN_SRA    = 6'h03;
    localparam logic [5:0] c_FN_JR     = 6'h08;
    localparam logic [5:0] c_FN_JALR   = 6'h09;
    localparam logic [5:0] c_FN_MFHI   = 6'h10;
    localparam logic [5:0] c_FN_MFLO   = 6'h12;

    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extOp;
        logic       luiOp;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       hiLoSel;
        logic [3:0] aluOp;
        logic [2:0] branchOp;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdState_t;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic w_isR, w_functLegal, w_opLegal, w_legal;
    logic w_isJ, w_isJal, w_isJr, w_isJalr, w_isMd, w_isMfhi, w_isMflo;

    assign w_isR    = (bus.OpCode == c_OP_RTYPE);
    assign w_isJ    = (bus.OpCode == c_OP_J);
    assign w_isJal  = (bus.OpCode == c_OP_JAL);
    assign w_isJr   = w_isR && (bus.Funct == c_FN_JR);
    assign w_isJalr = w_isR && (bus.Funct == c_FN_JALR);
    assign w_isMfhi = w_isR && (bus.Funct == c_FN_MFHI);
    assign w_isMflo = w_isR && (bus.Funct == c_FN_MFLO);
    // funct 0x18..0x1b: mult, multu, div, divu
    assign w_isMd   = w_isR && (bus.Funct[5:2] == 4'b0110);

    always_comb begin
        w_functLegal = 1'b0;
        case (bus.Funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b: w_functLegal = 1'b1;
            default:      w_functLegal = 1'b0;
        endcase
    end

    always_comb begin
        w_opLegal = 1'b0;
        if ((bus.OpCode >= 6'h01) && (bus.OpCode <= 6'h0f)) begin
            w_opLegal = 1'b1;
        end else if ((bus.OpCode == c_OP_LW) || (bus.OpCode == c_OP_SW)) begin
            w_opLegal = 1'b1;
        end
    end

    assign w_legal = w_isR ? w_functLegal : w_opLegal;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    ctrl_t      w_dec;
    logic [1:0] w_pcSrc;
    logic       w_isJump;

    always_comb begin
        w_dec    = '0;
        w_pcSrc  = 2'b00;
        w_isJump = 1'b0;
        if (bus.id_valid) begin
            w_dec.aluSrcA  = w_isR && ((bus.Funct == c_FN_SLL) ||
                                       (bus.Funct == c_FN_SRL) ||
                                       (bus.Funct == c_FN_SRA));
            w_dec.aluSrcB  = !w_isR;
            w_dec.extOp    = !(w_isR || (bus.OpCode == c_OP_ANDI) ||
                               (bus.OpCode == c_OP_ORI) || (bus.OpCode == c_OP_XORI));
            w_dec.luiOp    = (bus.OpCode == c_OP_LUI);
            w_dec.memRead  = (bus.OpCode == c_OP_LW);
            w_dec.memWrite = (bus.OpCode == c_OP_SW);
            w_dec.hiLoSel  = w_isMfhi;

            if (w_isJal || w_isJalr) begin
                w_dec.regDst = 2'b10;
            end else if (w_isR) begin
                w_dec.regDst = 2'b01;
            end

            if (bus.OpCode == c_OP_LW) begin
                w_dec.memToReg = 2'b01;
            end else if (w_isJal || w_isJalr) begin
                w_dec.memToReg = 2'b10;
            end else if (w_isMfhi || w_isMflo) begin
                w_dec.memToReg = 2'b11;
            end

            w_dec.aluOp[3] = bus.OpCode[0];
            if (w_isR) begin
                w_dec.aluOp[2:0] = 3'b010;
            end else begin
                case (bus.OpCode)
                    c_OP_ORI:              w_dec.aluOp[2:0] = 3'b001;
                    c_OP_XORI:             w_dec.aluOp[2:0] = 3'b011;
                    c_OP_ANDI:             w_dec.aluOp[2:0] = 3'b100;
                    c_OP_SLTI, c_OP_SLTIU: w_dec.aluOp[2:0] = 3'b101;
                    default:               w_dec.aluOp[2:0] = 3'b000;
                endcase
            end

            case (bus.OpCode)
                c_OP_BEQ:    w_dec.branchOp = 3'b001;
                c_OP_BNE:    w_dec.branchOp = 3'b010;
                c_OP_BLEZ:   w_dec.branchOp = 3'b011;
                c_OP_BGTZ:   w_dec.branchOp = 3'b100;
                c_OP_REGIMM: w_dec.branchOp = 3'b101;
                default:     w_dec.branchOp = 3'b000;
            endcase

            w_dec.regWrite = !((bus.OpCode == c_OP_SW) || w_isJ ||
                               (bus.OpCode == c_OP_REGIMM) ||
                               ((bus.OpCode >= c_OP_BEQ) && (bus.OpCode <= c_OP_BGTZ)) ||
                               w_isJr || w_isMd);

            if (w_isJ || w_isJal) begin
                w_pcSrc = 2'b01;
            end else if (w_isJr || w_isJalr) begin
                w_pcSrc = 2'b10;
            end
            w_isJump = w_isJ || w_isJal || w_isJr || w_isJalr;

            // Illegal encodings must not change architectural state
            if (!w_legal) begin
                w_dec.illegal  = 1'b1;
                w_dec.regWrite = 1'b0;
                w_dec.memRead  = 1'b0;
                w_dec.memWrite = 1'b0;
                w_dec.branchOp = 3'b000;
                w_pcSrc        = 2'b00;
                w_isJump       = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard / MD launch
    // ------------------------------------------------------------------
    mdState_t         r_state, w_stateNxt;
    logic [CNT_W-1:0] r_cnt, w_cntNxt;
    logic             r_mdDone, w_mdDoneNxt;
    logic             w_mdBusy, w_mdDep, w_stallOut, w_mdStart;

    assign w_mdBusy   = (r_state == S_BUSY);
    assign w_mdDep    = bus.id_valid && (w_isMd || w_isMfhi || w_isMflo);
    assign w_stallOut = bus.stall_in || (w_mdDep && w_mdBusy);
    assign w_mdStart  = bus.id_valid && w_isMd && !bus.flush_in && !w_stallOut;

    // ------------------------------------------------------------------
    // MD sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mdDone <= 1'b0;
        end else begin
            r_state  <= w_stateNxt;
            r_cnt    <= w_cntNxt;
            r_mdDone <= w_mdDoneNxt;
        end
    end

    always_comb begin
        w_stateNxt  = r_state;
        w_cntNxt    = r_cnt;
        w_mdDoneNxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mdStart) begin
                    w_stateNxt = S_BUSY;
                    // Funct[1] separates div/divu from mult/multu
                    w_cntNxt   = bus.Funct[1] ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_stateNxt  = S_IDLE;
                    w_mdDoneNxt = 1'b1;
                end else begin
                    w_cntNxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_stateNxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register: flush and stall both inject a bubble
    // ------------------------------------------------------------------
    ctrl_t r_ex;
    logic  r_exValid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exValid <= 1'b0;
            r_ex      <= '0;
        end else if (bus.flush_in || w_stallOut) begin
            r_exValid <= 1'b0;
            r_ex      <= '0;
        end else begin
            r_exValid <= bus.id_valid;
            r_ex      <= w_dec;
        end
    end

    assign bus.id_PCSrc    = w_pcSrc;
    assign bus.id_IsJump   = w_isJump;
    assign bus.stall_out   = w_stallOut;
    assign bus.ex_valid    = r_exValid;
    assign bus.ex_RegWrite = r_ex.regWrite;
    assign bus.ex_MemRead  = r_ex.memRead;
    assign bus.ex_MemWrite = r_ex.memWrite;
    assign bus.ex_ALUSrcA  = r_ex.aluSrcA;
    assign bus.ex_ALUSrcB  = r_ex.aluSrcB;
    assign bus.ex_ExtOp    = r_ex.extOp;
    assign bus.ex_LuiOp    = r_ex.luiOp;
    assign bus.ex_RegDst   = r_ex.regDst;
    assign bus.ex_MemToReg = r_ex.memToReg;
    assign bus.ex_HiLoSel  = r_ex.hiLoSel;
    assign bus.ex_ALUOp    = r_ex.aluOp;
    assign bus.ex_BranchOp = r_ex.branchOp;
    assign bus.ex_illegal  = r_ex.illegal;
    assign bus.md_start    = w_mdStart;
    assign bus.md_op       = w_mdStart ? bus.Funct[1:0] : 2'b00;
    assign bus.md_busy     = w_mdBusy;
    assign bus.md_done     = r_mdDone;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Directed self-checking bench for pipe_ctrl_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFails  = 0;

    pipe_ctrl_unit_if bus ();

    pipe_ctrl_unit #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // {RW MR MW A B E L}_{RegDst}_{MemToReg}_{HiLo}_{ALUOp}_{Branch}_{illegal}
    localparam logic [19:0] M_ALL = 20'hfffff;
    localparam logic [19:0] M_ILL = 20'b1110000_00_00_0_0000_111_1;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] exp;
        logic [19:0] mask;
        logic [2:0]  jmp;
    } vec_t;

    function automatic logic [19:0] exBundle();
        return {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_ALUSrcA,
                bus.ex_ALUSrcB, bus.ex_ExtOp, bus.ex_LuiOp, bus.ex_RegDst,
                bus.ex_MemToReg, bus.ex_HiLoSel, bus.ex_ALUOp, bus.ex_BranchOp,
                bus.ex_illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        bus.id_valid = v;
        bus.OpCode   = op;
        bus.Funct    = fn;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        drive(1'b1, 6'h08, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({bus.ex_valid, exBundle(), bus.md_busy, bus.md_done} !== 23'd0) begin
            nFails++;
            $display("FAIL reset_state: got valid=%b bundle=%b busy=%b done=%b, want all 0",
                     bus.ex_valid, exBundle(), bus.md_busy, bus.md_done);
        end
        reset = 1'b1;
        step();
        nChecks++;
        if ({bus.ex_valid, bus.ex_RegWrite, bus.ex_ALUSrcB, bus.ex_ExtOp, bus.ex_ALUOp} !== 8'b1111_0000) begin
            nFails++;
            $display("FAIL reset_release_addi: got v=%b rw=%b b=%b ext=%b aluop=%b, want 1 1 1 1 0000",
                     bus.ex_valid, bus.ex_RegWrite, bus.ex_ALUSrcB, bus.ex_ExtOp, bus.ex_ALUOp);
        end
    endtask

    task automatic test_decode();
        vec_t v [15];
        v[0]  = {6'h23, 6'h00, 20'b1100110_00_01_0_1000_000_0, M_ALL, 3'b000}; // lw
        v[1]  = {6'h03, 6'h00, 20'b1000110_10_10_0_1000_000_0, M_ALL, 3'b011}; // jal
        v[2]  = {6'h00, 6'h08, 20'b0000000_01_00_0_0010_000_0, M_ALL, 3'b101}; // jr
        v[3]  = {6'h0d, 6'h00, 20'b1000100_00_00_0_1001_000_0, M_ALL, 3'b000}; // ori
        v[4]  = {6'h3f, 6'h00, 20'b0000000_00_00_0_0000_000_1, M_ILL, 3'b000}; // bad opcode
        v[5]  = {6'h00, 6'h00, 20'b1001000_01_00_0_0010_000_0, M_ALL, 3'b000}; // sll
        v[6]  = {6'h04, 6'h00, 20'b0000110_00_00_0_0000_001_0, M_ALL, 3'b000}; // beq
        v[7]  = {6'h2b, 6'h00, 20'b0010110_00_00_0_1000_000_0, M_ALL, 3'b000}; // sw
        v[8]  = {6'h0f, 6'h00, 20'b1000111_00_00_0_1000_000_0, M_ALL, 3'b000}; // lui
        v[9]  = {6'h0a, 6'h00, 20'b1000110_00_00_0_0101_000_0, M_ALL, 3'b000}; // slti
        v[10] = {6'h00, 6'h09, 20'b1000000_10_10_0_0010_000_0, M_ALL, 3'b101}; // jalr
        v[11] = {6'h00, 6'h10, 20'b1000000_01_11_1_0010_000_0, M_ALL, 3'b000}; // mfhi
        v[12] = {6'h0c, 6'h00, 20'b1000100_00_00_0_0100_000_0, M_ALL, 3'b000}; // andi
        v[13] = {6'h07, 6'h00, 20'b0000110_00_00_0_1000_100_0, M_ALL, 3'b000}; // bgtz
        v[14] = {6'h00, 6'h01, 20'b0000000_00_00_0_0000_000_1, M_ILL, 3'b000}; // bad funct
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, v[i].op, v[i].fn);
            #1;
            nChecks++;
            if ({bus.id_PCSrc, bus.id_IsJump} !== v[i].jmp) begin
                nFails++;
                $display("FAIL decode_jump[%0d]: got pcsrc/isjump=%b, want %b",
                         i, {bus.id_PCSrc, bus.id_IsJump}, v[i].jmp);
            end
            step();
            nChecks++;
            if (((exBundle() & v[i].mask) !== v[i].exp) || (bus.ex_valid !== 1'b1)) begin
                nFails++;
                $display("FAIL decode_ex[%0d]: got valid=%b bundle=%b, want valid=1 bundle=%b (mask %b)",
                         i, bus.ex_valid, exBundle(), v[i].exp, v[i].mask);
            end
        end
        drive(1'b0, 6'h23, 6'h00);
        step();
        nChecks++;
        if ({bus.ex_valid, exBundle()} !== 21'd0) begin
            nFails++;
            $display("FAIL decode_invalid: got valid=%b bundle=%b, want all 0", bus.ex_valid, exBundle());
        end
    endtask

    task automatic test_mult_mflo();
        drive(1'b1, 6'h00, 6'h18);
        #1;
        nChecks++;
        if ({bus.md_start, bus.md_op, bus.stall_out} !== 4'b1000) begin
            nFails++;
            $display("FAIL mult_start: got start/op/stall=%b, want 1000", {bus.md_start, bus.md_op, bus.stall_out});
        end
        step();
        drive(1'b1, 6'h00, 6'h12);
        for (int t = 1; t <= 4; t++) begin
            #1;
            nChecks++;
            if ({bus.md_busy, bus.stall_out, bus.md_start, bus.md_done, bus.ex_valid} !== {4'b1100, (t == 1)}) begin
                nFails++;
                $display("FAIL mult_busy_t%0d: got busy/stall/start/done/valid=%b, want %b",
                         t, {bus.md_busy, bus.stall_out, bus.md_start, bus.md_done, bus.ex_valid},
                         {4'b1100, (t == 1)});
            end
            step();
        end
        #1;
        nChecks++;
        if ({bus.md_busy, bus.md_done, bus.stall_out, bus.ex_valid} !== 4'b0100) begin
            nFails++;
            $display("FAIL mult_done_t5: got busy/done/stall/valid=%b, want 0100",
                     {bus.md_busy, bus.md_done, bus.stall_out, bus.ex_valid});
        end
        step();
        drive(1'b0, 6'h00, 6'h00);
        nChecks++;
        if ({bus.ex_valid, bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_HiLoSel, bus.md_done} !== 6'b111100) begin
            nFails++;
            $display("FAIL mflo_capture: got valid/rw/m2r/hilo/done=%b, want 111100",
                     {bus.ex_valid, bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_HiLoSel, bus.md_done});
        end
    endtask

    task automatic test_back_to_back();
        int  busyCnt;
        logic seen;
        drive(1'b1, 6'h00, 6'h1a);
        #1;
        nChecks++;
        if ({bus.md_start, bus.md_op} !== 3'b110) begin
            nFails++;
            $display("FAIL div_start: got start/op=%b, want 110", {bus.md_start, bus.md_op});
        end
        step();
        drive(1'b1, 6'h00, 6'h1b);
        busyCnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (bus.md_done) begin
                seen = 1'b1;
                nChecks++;
                if ({bus.md_start, bus.md_op} !== 3'b111 || busyCnt != 32) begin
                    nFails++;
                    $display("FAIL divu_restart: got start/op=%b busy_cycles=%0d, want 111 and 32",
                             {bus.md_start, bus.md_op}, busyCnt);
                end
            end else begin
                if (bus.md_busy) busyCnt++;
                nChecks++;
                if ({bus.stall_out, bus.md_start} !== 2'b10) begin
                    nFails++;
                    $display("FAIL divu_wait[%0d]: got stall/start=%b, want 10", k, {bus.stall_out, bus.md_start});
                end
            end
            step();
        end
        if (!seen) begin
            nChecks++;
            nFails++;
            $display("FAIL div_done_timeout: got no md_done in 40 cycles, want one after 32");
        end
        // divu now in its first busy cycle: flush must not cancel it
        nChecks++;
        if (bus.md_busy !== 1'b1) begin
            nFails++;
            $display("FAIL divu_busy: got md_busy=%b, want 1", bus.md_busy);
        end
        drive(1'b1, 6'h00, 6'h12);
        bus.flush_in = 1'b1;
        #1;
        nChecks++;
        if ({bus.stall_out, bus.md_start} !== 2'b10) begin
            nFails++;
            $display("FAIL flush_busy_comb: got stall/start=%b, want 10", {bus.stall_out, bus.md_start});
        end
        step();
        bus.flush_in = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        nChecks++;
        if ({bus.ex_valid, bus.md_busy} !== 2'b01) begin
            nFails++;
            $display("FAIL flush_busy_keep: got valid/busy=%b, want 01", {bus.ex_valid, bus.md_busy});
        end
        busyCnt = 1;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.md_done) seen = 1'b1;
            else begin
                if (bus.md_busy) busyCnt++;
                step();
            end
        end
        nChecks++;
        if (!seen || busyCnt != 32) begin
            nFails++;
            $display("FAIL divu_duration: got done_seen=%b busy_cycles=%0d, want 1 and 32", seen, busyCnt);
        end
        step();
    endtask

    task automatic test_flush_stall();
        int   busyCnt;
        logic seen;
        drive(1'b1, 6'h00, 6'h1a);
        bus.flush_in = 1'b1;
        bus.stall_in = 1'b1;
        #1;
        nChecks++;
        if (bus.md_start !== 1'b0) begin
            nFails++;
            $display("FAIL flush_stall_start: got md_start=%b, want 0", bus.md_start);
        end
        step();
        nChecks++;
        if ({bus.ex_valid, bus.md_busy} !== 2'b00) begin
            nFails++;
            $display("FAIL flush_stall_bubble: got valid/busy=%b, want 00", {bus.ex_valid, bus.md_busy});
        end
        bus.flush_in = 1'b0;
        drive(1'b1, 6'h2b, 6'h00);
        step();
        nChecks++;
        if ({bus.ex_valid, bus.ex_MemWrite, bus.stall_out} !== 3'b001) begin
            nFails++;
            $display("FAIL stall_sw: got valid/memwrite/stall=%b, want 001",
                     {bus.ex_valid, bus.ex_MemWrite, bus.stall_out});
        end
        drive(1'b1, 6'h00, 6'h19);
        #1;
        nChecks++;
        if (bus.md_start !== 1'b0) begin
            nFails++;
            $display("FAIL stall_suppress: got md_start=%b, want 0", bus.md_start);
        end
        step();
        bus.stall_in = 1'b0;
        #1;
        nChecks++;
        if ({bus.md_busy, bus.md_start, bus.md_op} !== 4'b0101) begin
            nFails++;
            $display("FAIL stall_retry: got busy/start/op=%b, want 0101", {bus.md_busy, bus.md_start, bus.md_op});
        end
        step();
        drive(1'b0, 6'h00, 6'h00);
        busyCnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bus.md_done) seen = 1'b1;
            else begin
                if (bus.md_busy) busyCnt++;
                step();
            end
        end
        nChecks++;
        if (!seen || busyCnt != 4) begin
            nFails++;
            $display("FAIL multu_duration: got done_seen=%b busy_cycles=%0d, want 1 and 4", seen, busyCnt);
        end
        step();
    endtask

    task automatic test_reset_busy();
        int   busyCnt;
        int   doneCnt;
        logic seen;
        drive(1'b1, 6'h00, 6'h1a);
        step();
        drive(1'b0, 6'h00, 6'h00);
        repeat (21) step();
        nChecks++;
        if (bus.md_busy !== 1'b1) begin
            nFails++;
            $display("FAIL pre_reset_busy: got md_busy=%b, want 1", bus.md_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        nChecks++;
        if ({bus.md_busy, bus.md_done, bus.ex_valid} !== 3'b000) begin
            nFails++;
            $display("FAIL async_reset_busy: got busy/done/valid=%b, want 000",
                     {bus.md_busy, bus.md_done, bus.ex_valid});
        end
        @(posedge clk);
        #1;
        reset   = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.md_done) doneCnt++;
            step();
        end
        nChecks++;
        if (doneCnt != 0) begin
            nFails++;
            $display("FAIL reset_no_done: got %0d md_done pulses, want 0", doneCnt);
        end
        drive(1'b1, 6'h00, 6'h18);
        step();
        drive(1'b0, 6'h00, 6'h00);
        busyCnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bus.md_done) seen = 1'b1;
            else begin
                if (bus.md_busy) busyCnt++;
                step();
            end
        end
        nChecks++;
        if (!seen || busyCnt != 4) begin
            nFails++;
            $display("FAIL mult_after_reset: got done_seen=%b busy_cycles=%0d, want 1 and 4", seen, busyCnt);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult_mflo();
        test_back_to_back();
        test_flush_stall();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
